btb: RTL

- Branch target buffer feeding the IF-stage meta predictor.
- Outputs Hit_BTB and Alt_PC_BTB for the current IF_PC; both are combinational from IF_PC so the predictor can choose the next fetch address in the same cycle.
- Trained from ID-stage branch resolution (ID_PC, Alt_PC_ID, Is_Branch, Is_Taken).
- 2-way set-associative, 1-bit LRU per set.

---
 rtl/btb_pkg.sv | 34 +++
 rtl/btb_way.sv | 58 +++++
 rtl/btb.sv | 99 +++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// Branch target buffer shared definitions.
//   BTB_SETS      default number of sets
//   BTB_IDX_W     index width for the default set count
//   BTB_TAG_W     full tag width for the default set count (30 - index)
//   TAG_MAX_W     storage width of a tag field, wide enough for the smallest
//                 legal set count (4 sets -> 28-bit tag)
//   btb_entry_t   read view of one way entry {valid, tag, target}
//   btb_index()   PC[idx_w+1:2]
//   btb_tag()     PC[31:idx_w+2], zero-extended to TAG_MAX_W
package btb_pkg;

   localparam int BTB_SETS  = 64;
   localparam int BTB_IDX_W = $clog2(BTB_SETS);
   localparam int BTB_TAG_W = 30 - BTB_IDX_W;
   localparam int TAG_MAX_W = 28;

   typedef struct packed {
      logic                 valid;
      logic [TAG_MAX_W-1:0] tag;
      logic [31:0]          target;
   } btb_entry_t;

   // Index is returned 10 bits wide (max SETS = 1024); callers truncate.
   function automatic logic [9:0] btb_index(input logic [31:0] pc, input int idx_w);
      return 10'((pc >> 2) & ((32'd1 << idx_w) - 32'd1));
   endfunction

   // Tags are stored zero-extended, so equality on the wide field is
   // equality on the true TAG_W-bit tag.
   function automatic logic [TAG_MAX_W-1:0] btb_tag(input logic [31:0] pc, input int idx_w);
      return TAG_MAX_W'(pc >> (idx_w + 2));
   endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the branch target buffer.
// Holds per-set valid/tag/target. Two compare ports: a read port for the
// fetch-side lookup and a probe port on the training set, used by the top to
// detect a training hit and to find invalid ways for victim selection.
// Ports:
//   CLK, RESET          clock, async active-low reset (clears valid only)
//   i_rd_idx/i_rd_tag   lookup set/tag; o_rd_hit, o_rd_target result
//   i_wr_idx/i_wr_tag   training set/tag; o_wr_hit, o_wr_valid probe result
//   i_we, i_wr_target   write enable and new target for the training set
module btb_way
   import btb_pkg::*;
#(
   parameter int SETS = BTB_SETS,
   localparam int IDX_W = $clog2(SETS)
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [IDX_W-1:0]     i_rd_idx,
   input  logic [TAG_MAX_W-1:0] i_rd_tag,
   output logic                 o_rd_hit,
   output logic [31:0]          o_rd_target,
   input  logic [IDX_W-1:0]     i_wr_idx,
   input  logic [TAG_MAX_W-1:0] i_wr_tag,
   output logic                 o_wr_hit,
   output logic                 o_wr_valid,
   input  logic                 i_we,
   input  logic [31:0]          i_wr_target
);

   logic [SETS-1:0]      r_valid;
   logic [TAG_MAX_W-1:0] r_tag [SETS];
   logic [31:0]          r_tgt [SETS];

   btb_entry_t w_rd_ent;
   btb_entry_t w_wr_ent;

   assign w_rd_ent = '{valid: r_valid[i_rd_idx], tag: r_tag[i_rd_idx], target: r_tgt[i_rd_idx]};
   assign w_wr_ent = '{valid: r_valid[i_wr_idx], tag: r_tag[i_wr_idx], target: r_tgt[i_wr_idx]};

   assign o_rd_hit    = w_rd_ent.valid && (w_rd_ent.tag == i_rd_tag);
   assign o_rd_target = w_rd_ent.target;
   assign o_wr_hit    = w_wr_ent.valid && (w_wr_ent.tag == i_wr_tag);
   assign o_wr_valid  = w_wr_ent.valid;

   // Only valid bits are reset; stale tag/target behind a cleared valid is harmless.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)    r_valid <= '0;
      else if (i_we) r_valid[i_wr_idx] <= 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (i_we) begin
         r_tag[i_wr_idx] <= i_wr_tag;
         r_tgt[i_wr_idx] <= i_wr_target;
      end
   end

endmodule

// File: rtl/btb.sv
// Branch target buffer, 2-way set-associative with 1-bit LRU per set.
// Lookup is combinational from IF_PC; training from ID-stage taken branches
// takes effect at the next rising edge (lookups in the training cycle see
// the old contents).
// Ports:
//   CLK, RESET (async active-low), STALL (blocks training)
//   IF_PC                      fetch PC looked up
//   ID_PC, Alt_PC_ID           resolving branch PC and its taken target
//   Is_Branch, Is_Taken        ID branch qualifiers
//   Hit_BTB, Alt_PC_BTB        lookup result (target is 0 on miss)
// Build option: define BTB_BYPASS_EN to forward a same-cycle training of the
// fetched PC straight to the lookup outputs.
module btb
   import btb_pkg::*;
#(
   parameter int SETS = BTB_SETS
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic [31:0] IF_PC,
   input  logic [31:0] ID_PC,
   input  logic [31:0] Alt_PC_ID,
   input  logic        Is_Branch,
   input  logic        Is_Taken,
   output logic        Hit_BTB,
   output logic [31:0] Alt_PC_BTB
);

   localparam int IDX_W = $clog2(SETS);

   logic [IDX_W-1:0]     w_rd_idx, w_wr_idx;
   logic [TAG_MAX_W-1:0] w_rd_tag, w_wr_tag;
   logic [1:0]           w_rd_hit, w_wr_hit, w_wr_valid, w_we;
   logic [1:0][31:0]     w_rd_tgt;
   logic                 w_train, w_vic;
   logic [SETS-1:0]      r_lru;   // way to evict next

   assign w_rd_idx = IDX_W'(btb_index(IF_PC, IDX_W));
   assign w_wr_idx = IDX_W'(btb_index(ID_PC, IDX_W));
   assign w_rd_tag = btb_tag(IF_PC, IDX_W);
   assign w_wr_tag = btb_tag(ID_PC, IDX_W);
   assign w_train  = Is_Branch && Is_Taken && !STALL;

   for (genvar w = 0; w < 2; w++) begin : g_way
      btb_way #(.SETS(SETS)) u_way (
         .CLK         (CLK),
         .RESET       (RESET),
         .i_rd_idx    (w_rd_idx),
         .i_rd_tag    (w_rd_tag),
         .o_rd_hit    (w_rd_hit[w]),
         .o_rd_target (w_rd_tgt[w]),
         .i_wr_idx    (w_wr_idx),
         .i_wr_tag    (w_wr_tag),
         .o_wr_hit    (w_wr_hit[w]),
         .o_wr_valid  (w_wr_valid[w]),
         .i_we        (w_we[w]),
         .i_wr_target (Alt_PC_ID)
      );
   end

   // Way to write: the hitting way (way 0 first), else first invalid way,
   // else the LRU way.
   always_comb begin
      w_vic = 1'b0;
      if (w_wr_hit[0])        w_vic = 1'b0;
      else if (w_wr_hit[1])   w_vic = 1'b1;
      else if (!w_wr_valid[0]) w_vic = 1'b0;
      else if (!w_wr_valid[1]) w_vic = 1'b1;
      else                    w_vic = r_lru[w_wr_idx];
   end

   assign w_we = !w_train ? 2'b00 : (w_vic ? 2'b10 : 2'b01);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)       r_lru <= '0;
      else if (w_train) r_lru[w_wr_idx] <= ~w_vic;
   end

   // Lookup; valid bits clear asynchronously so this reads as a miss in reset.
   always_comb begin
      Hit_BTB    = 1'b0;
      Alt_PC_BTB = 32'h0;
      if (w_rd_hit[0]) begin
         Hit_BTB    = 1'b1;
         Alt_PC_BTB = w_rd_tgt[0];
      end else if (w_rd_hit[1]) begin
         Hit_BTB    = 1'b1;
         Alt_PC_BTB = w_rd_tgt[1];
      end
`ifdef BTB_BYPASS_EN
      if (w_train && RESET && (ID_PC[31:2] == IF_PC[31:2])) begin
         Hit_BTB    = 1'b1;
         Alt_PC_BTB = Alt_PC_ID;
      end
`endif
   end

endmodule
